// File: rtl/key_history_hex.sv
// Shift-register history of the last NUM_BYTES codes, presented as HEX nibbles plus a per-digit blank mask.
// Optional KEY_HISTORY_BLINK_EN: newest byte blinks with a BLINK_DIV-cycle half-period. All outputs registered, latency 1.
module key_history_hex #(
    parameter int NUM_BYTES = 3,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [7:0]             DATA_IN,
    input  logic                   DATA_VALID,
    input  logic                   FREEZE,
    input  logic                   CLEAR,
    output logic [8*NUM_BYTES-1:0] NIBBLES,
    output logic [2*NUM_BYTES-1:0] BLANK,
    output logic [7:0]             COUNT,
    output logic                   DROP
);

    typedef logic [$clog2(BLINK_DIV)-1:0] blink_cnt_t;

    // Byte i lives at [8i+7:8i], so its high nibble lands on digit 2i+1 with no remapping.
    logic [8*NUM_BYTES-1:0] r_hist;
    logic [NUM_BYTES-1:0]   r_valid;
    logic [7:0]             r_count;
    logic                   r_drop;
    logic [2*NUM_BYTES-1:0] r_blank;

    logic                   w_accept;
    logic                   w_drop;
    logic [8*NUM_BYTES-1:0] w_hist_nxt;
    logic [NUM_BYTES-1:0]   w_valid_nxt;
    logic [7:0]             w_count_nxt;
    logic [2*NUM_BYTES-1:0] w_blank_nxt;

    assign w_accept = DATA_VALID & ~FREEZE & ~CLEAR;
    assign w_drop   = DATA_VALID &  FREEZE & ~CLEAR;

    always_comb begin
        w_hist_nxt  = r_hist;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        if (CLEAR) begin
            w_hist_nxt  = '0;
            w_valid_nxt = '0;
            w_count_nxt = '0;
        end else if (w_accept) begin
            w_hist_nxt[7:0] = DATA_IN;
            w_valid_nxt[0]  = 1'b1;
            for (int i = 1; i < NUM_BYTES; i++) begin
                w_hist_nxt[8*i +: 8] = r_hist[8*(i-1) +: 8];
                w_valid_nxt[i]       = r_valid[i-1];
            end
            w_count_nxt = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
        end
    end

`ifdef KEY_HISTORY_BLINK_EN
    blink_cnt_t r_blink_cnt;
    logic       r_phase;
    blink_cnt_t w_blink_cnt_nxt;
    logic       w_phase_nxt;

    // An accept restarts the visible half-period so a fresh byte is never hidden immediately.
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt + blink_cnt_t'(1);
        w_phase_nxt     = r_phase;
        if (w_accept) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = 1'b0;
        end else if (r_blink_cnt == blink_cnt_t'(BLINK_DIV - 1)) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
        end
    end
`endif

    always_comb begin
        w_blank_nxt = '1;
        for (int i = 0; i < NUM_BYTES; i++) begin
            w_blank_nxt[2*i +: 2] = {2{~w_valid_nxt[i]}};
        end
`ifdef KEY_HISTORY_BLINK_EN
        if (w_phase_nxt && w_valid_nxt[0]) begin
            w_blank_nxt[1:0] = 2'b11;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hist  <= '0;
            r_valid <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
            r_blank <= '1;
        end else begin
            r_hist  <= w_hist_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            r_drop  <= w_drop;
            r_blank <= w_blank_nxt;
        end
    end

    assign NIBBLES = r_hist;
    assign BLANK   = r_blank;
    assign COUNT   = r_count;
    assign DROP    = r_drop;

endmodule
